four_bank_mem: RTL
==================

# four_bank_mem

Word-addressed, four-way interleaved main-memory block sitting directly downstream of the direct-mapped cache controller. It accepts one read or write per cycle, steers it to a bank selected by low word-address bits, and holds that bank busy for a fixed number of cycles. Read data returns on a fixed pipeline latency. Per-bank busy flags and a same-cycle stall let the controller overlap line-fill accesses across banks.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width.
- `DATA_W`, 16: word width.
- `ROWS`, 256: words per bank; total capacity is 4*ROWS words.
- `BANK_CYCLES`, 4: cycles a bank stays busy after accepting a request (2..7).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr`  in  ADDR_W  byte address; bit 0 is the byte offset, bits [2:1] select the bank, bits [log2(ROWS)+2:3] select the row.
- `data_in`  in  DATA_W  write data.
- `wr`  in  1  write request.
- `rd`  in  1  read request.
- `data_out`  out  DATA_W  read data, valid when `rd_valid`=1.
- `rd_valid`  out  1  one-cycle pulse that qualifies `data_out`.
- `stall`  out  1  combinational; request present but target bank busy (or request rejected as an error).
- `busy`  out  4  per-bank busy flags, registered.
- `err`  out  1  combinational request error (see Configuration).

## Operation
- Request present in cycle T when `rd`|`wr`=1. Bank b=`addr[2:1]`.
- Accept in T iff request present, `busy[b]`=0, and no error. On accept, `stall`=0.
- Not accepted while a request is present: `stall`=1 and no state changes. The requester holds `addr`/`data_in`/`rd`/`wr` until accepted.
- Accepted write: the array word is written at the edge ending T.
- Accepted read: the array is read at the edge ending T and registered through a second stage. `data_out` and `rd_valid`=1 appear in cycle T+2.
- Busy counter per bank, 3 bits:
  - Loaded with BANK_CYCLES on accept.
  - Decrements each cycle while nonzero.
  - `busy[b]` = (counter != 0), so it is high for cycles T+1..T+BANK_CYCLES.
- Back-to-back: in T+1, a request to a different bank is accepted. With four distinct banks, a full line is accepted in cycles T..T+3, and reads return in T+2..T+5.
- Same-bank request in T+1..T+BANK_CYCLES stalls. It is accepted in T+BANK_CYCLES+1.
- Read-after-write to the same word therefore always observes the written data.
- Bank state machine, per bank: IDLE -> BUSY on accept; BUSY -> IDLE when the counter reaches 1 and decrements to 0. No other states.
- `rd_valid` pulses back-to-back when reads are accepted on consecutive cycles. There is no output backpressure.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `busy`=4'b0000, `data_out`=0, `rd_valid`=0.
  - All counters 0, and the read pipeline is flushed.
  - Memory contents are undefined and are not cleared.
- Reset asserted mid-operation: in-flight reads are dropped and produce no `rd_valid` after release. Writes accepted before the reset edge remain in the array.
- First request is accepted in the first cycle after `rst_n` deasserts.
- `stall` and `err` are purely combinational from `rd`, `wr`, `addr` and `busy`. They are valid in the same cycle and have no reset value of their own.
- Latency:
  - Read: 2 cycles, accept to `rd_valid`.
  - Write: commits at the accept edge.
  - Bank occupancy: BANK_CYCLES.
- Row index wraps modulo ROWS. Address bits above the row field are ignored.

## Configuration
- `MEM_ERR_EN` defined:
  - `err`=1 when `rd`&`wr`=1, or when a request has `addr[0]`=1.
  - An erroring request is never accepted, `stall`=1 together with `err`, and there are no busy or array side effects.
- `MEM_ERR_EN` undefined:
  - `err` is tied 0 and `addr[0]` is ignored.
  - `rd`&`wr`=1 is treated as a write only, with no `rd_valid`.

## Structure
- Package `mem_pkg` holds:
  - Constants `NUM_BANKS`=4, `BANK_SEL_LO`=1, `RD_LAT`=2.
  - Typedef `bank_idx_t` (2-bit).
  - Typedef `busy_cnt_t` (3-bit).
- Sub-module `mem_bank`: one ROWS x DATA_W array, its busy counter and its first read register. It is instantiated four times.
- The top level contains bank decode, accept/stall/err logic, the output mux and the second read stage.

## Test plan
- Reset, then read addr 0x0000 with `busy`=0 -> accepted with `stall`=0; `rd_valid`=1 two cycles later; `busy`=4'b0001 for exactly 4 cycles.
- Write 0xBEEF to 0x0010, then immediately read 0x0010 -> read stalls 4 cycles, is accepted in cycle 5, and returns `data_out`=0xBEEF.
- Reads to 0x0100, 0x0102, 0x0104, 0x0106 on consecutive cycles -> all accepted without stall; four consecutive `rd_valid` pulses with the previously written data, in order.
- Read to 0x0008 then 0x0000 next cycle (both bank 0) -> second request: `stall`=1 for cycles T+1..T+4, accepted at T+5.
- Pulse `rst_n` low one cycle after accepting a read -> no `rd_valid` ever appears; `busy`=0 immediately.
- With `MEM_ERR_EN`, read addr 0x0003 and `rd`=`wr`=1 at 0x0020 -> `err`=1, `stall`=1, `busy` unchanged, memory at 0x0020 unmodified.

Source files
------------

// File: rtl/four_bank_mem_pkg.sv
// Shared constants and types for the four-way interleaved main memory.
// Bank select sits just above the byte-offset bit; read data returns RD_LAT cycles after accept.
package mem_pkg;
    localparam int NUM_BANKS   = 4;
    localparam int BANK_SEL_LO = 1;
    localparam int RD_LAT      = 2;

    typedef logic [1:0] bank_idx_t;
    typedef logic [2:0] busy_cnt_t;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_BUSY = 1'b1
    } bank_state_t;
endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller (master) and four_bank_mem (slave).
// stall/err are same-cycle responses; data_out is qualified by rd_valid.
interface four_bank_mem_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic                 rd_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

// File: rtl/four_bank_mem_bank.sv
// One memory bank: ROWS x DATA_W array, occupancy counter/FSM, first read register.
// Latency: write commits at accept edge, read data registered 1 cycle after accept.
// Backpressure: busy is high for BANK_CYCLES cycles after each accept.
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ROWS        = 256,
    parameter int BANK_CYCLES = 4,
    parameter int ROW_W       = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              we,
    input  logic              re,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdat,
    output logic              rvld
);
    logic [DATA_W-1:0] mem [ROWS];
    bank_state_t       state_q, state_d;
    busy_cnt_t         cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // sel is only ever asserted while idle; the top gates accept on busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BANK_IDLE: begin
                if (sel) begin
                    state_d = BANK_BUSY;
                    cnt_d   = busy_cnt_t'(BANK_CYCLES);
                end
            end
            BANK_BUSY: begin
                cnt_d = cnt_q - busy_cnt_t'(1);
                if (cnt_q == busy_cnt_t'(1)) begin
                    state_d = BANK_IDLE;
                end
            end
            default: begin
                state_d = BANK_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BANK_BUSY);

    // Array and read register carry no reset; validity is tracked by rvld.
    always_ff @(posedge clk) begin
        if (sel && we) begin
            mem[row] <= wdata;
        end
        if (sel && re) begin
            rdat <= mem[row];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvld <= 1'b0;
        end else begin
            rvld <= sel && re;
        end
    end
endmodule

// File: rtl/four_bank_mem.sv
// Four-way word-interleaved main memory; one request per cycle, bank = addr[2:1]. Optional MEM_ERR_EN.
// Latency: read data 2 cycles after accept, write commits at accept edge.
// Backpressure: combinational stall while the target bank is busy (or the request errors).
module four_bank_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int ROWS        = 256,
    parameter int BANK_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    four_bank_mem_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);

    bank_idx_t            bank;
    logic [ROW_W-1:0]     row;
    logic                 req;
    logic                 err_c;
    logic                 accept;
    logic                 is_read;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [NUM_BANKS-1:0] bank_rvld;
    logic [DATA_W-1:0]    bank_rdat [NUM_BANKS];
    logic [DATA_W-1:0]    mux_dat;
    logic                 mux_vld;
    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic                 unused_addr;

    assign bank = bus.addr[BANK_SEL_LO +: 2];
    assign row  = bus.addr[ROW_W+2:3];
    assign req  = bus.rd | bus.wr;

`ifdef MEM_ERR_EN
    assign err_c = (bus.rd & bus.wr) | (req & bus.addr[0]);
`else
    assign err_c = 1'b0;
`endif

    // Upper address bits alias onto the row field; the byte offset carries no data.
    assign unused_addr = ^{bus.addr[ADDR_W-1:ROW_W+3], bus.addr[0]};

    assign accept  = req & ~busy_vec[bank] & ~err_c;
    assign is_read = bus.rd & ~bus.wr;

    assign bus.stall = req & ~accept;
    assign bus.err   = err_c;
    assign bus.busy  = busy_vec;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DATA_W      (DATA_W),
            .ROWS        (ROWS),
            .BANK_CYCLES (BANK_CYCLES),
            .ROW_W       (ROW_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (accept && (bank == bank_idx_t'(g))),
            .we    (bus.wr),
            .re    (is_read),
            .row   (row),
            .wdata (bus.data_in),
            .busy  (busy_vec[g]),
            .rdat  (bank_rdat[g]),
            .rvld  (bank_rvld[g])
        );
    end

    // At most one bank holds valid read data in any cycle.
    always_comb begin
        mux_dat = '0;
        mux_vld = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_rvld[i]) begin
                mux_dat = bank_rdat[i];
                mux_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= mux_vld;
            if (mux_vld) begin
                data_q <= mux_dat;
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.rd_valid = valid_q;
endmodule
